bcd_to_bin_seq: RTL and testbench

- Sequential BCD-to-binary converter; inverse of the combinational binary-to-BCD path.
- Turns packed BCD digits collected from the keypad into a binary operand for the Booth multiplier datapath.
- Uses reverse double-dabble: shift right one bit per cycle, subtract 3 from any BCD nibble >= 8.
- start/ready/valid handshake; one conversion in flight at a time.

---
 rtl/bcd_to_bin_seq.sv | 143 ++++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD-to-binary converter (reverse double-dabble).
// The register {bcd_part, bin_part} is shifted right one bit per cycle.
// After each shift, every BCD nibble that is >= 8 has 3 subtracted.
// After BIN_W steps, bin_part holds the binary value of the input.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   start_i  conversion request, sampled only while ready_o=1
//   bcd_i    packed BCD operand, digit 0 in bits [3:0]
//   ready_o  idle and able to accept start_i (decoded from state)
//   valid_o  one-cycle pulse when bin_o/err_o are updated
//   bin_o    binary result, held until the next valid_o
//   err_o    set with valid_o when an input digit exceeds 9
module bcd_to_bin_seq #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [4*DIGITS-1:0]   bcd_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [BIN_W-1:0]      bin_o,
  output logic                  err_o
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   sr_bcd_q, sr_bcd_d;
  logic [BIN_W-1:0]   sr_bin_q, sr_bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               err_q, err_d;

  logic               digit_bad;
  logic [SR_W-1:0]    shifted;
  logic [BCD_W-1:0]   step_bcd;
  logic [BIN_W-1:0]   step_bin;
  logic [3:0]         nib;
  logic               last_step;

  // Flag any input digit outside 0..9.
  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_i[4*i +: 4] > 4'd9) digit_bad = 1'b1;
    end
  end

  // One reverse double-dabble step: shift right, then correct all nibbles in parallel.
  always_comb begin
    shifted  = {sr_bcd_q, sr_bin_q} >> 1;
    step_bin = shifted[BIN_W-1:0];
    step_bcd = shifted[SR_W-1:BIN_W];
    nib      = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      nib = shifted[BIN_W + 4*i +: 4];
      // Only nibbles >= 8 are corrected, so the subtraction cannot underflow.
      if (nib >= 4'd8) step_bcd[4*i +: 4] = nib - 4'd3;
    end
  end

  // cnt counts completed steps; the edge seeing BIN_W-1 performs the final one.
  assign last_step = (cnt_q == CNT_W'(BIN_W - 1));

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    sr_bcd_d = sr_bcd_q;
    sr_bin_d = sr_bin_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    bin_d    = bin_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (digit_bad) begin
            bin_d   = '0;
            err_d   = 1'b1;
            valid_d = 1'b1;
          end else begin
            sr_bcd_d = bcd_i;
            sr_bin_d = '0;
            cnt_d    = '0;
            state_d  = CONV;
          end
        end
      end
      CONV: begin
        sr_bcd_d = step_bcd;
        sr_bin_d = step_bin;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_step) begin
          bin_d   = step_bin;
          err_d   = 1'b0;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      sr_bcd_q <= '0;
      sr_bin_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      bin_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_bcd_q <= sr_bcd_d;
      sr_bin_q <= sr_bin_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      bin_q    <= bin_d;
      err_q    <= err_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = valid_q;
  assign bin_o   = bin_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq. A transaction-level model computes each result as a
// decimal sum of digits and tracks the handshake timing; a compare process
// checks every output each cycle. Directed literal checks pin the model.
module tb_bcd_to_bin_seq;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned BIN_W  = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic [15:0]       bcd_i = '0;
  logic              ready_o;
  logic              valid_o;
  logic [BIN_W-1:0]  bin_o;
  logic              err_o;

  int total = 0;
  int bad   = 0;
  int valid_cnt = 0;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .bcd_i   (bcd_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .bin_o   (bin_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bcd_bad(input logic [15:0] b);
    bcd_bad = 1'b0;
    for (int i = 0; i < 4; i++) if (int'(b[4*i +: 4]) > 9) bcd_bad = 1'b1;
  endfunction

  function automatic int bcd_val(input logic [15:0] b);
    int v;
    int w;
    v = 0;
    w = 1;
    for (int i = 0; i < 4; i++) begin
      v = v + int'(b[4*i +: 4]) * w;
      w = w * 10;
    end
    return v;
  endfunction

  // Transaction model: results are decimal values, timing is "BIN_W cycles busy".
  bit m_ready = 1'b1;
  bit m_valid = 1'b0;
  int m_bin   = 0;
  bit m_err   = 1'b0;
  int m_left  = 0;
  int m_pend  = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ready <= 1'b1;
      m_valid <= 1'b0;
      m_bin   <= 0;
      m_err   <= 1'b0;
      m_left  <= 0;
    end else begin
      m_valid <= 1'b0;
      if (m_ready) begin
        if (start_i) begin
          if (bcd_bad(bcd_i)) begin
            m_valid <= 1'b1;
            m_err   <= 1'b1;
            m_bin   <= 0;
          end else begin
            m_ready <= 1'b0;
            m_left  <= BIN_W;
            m_pend  <= bcd_val(bcd_i);
          end
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_ready <= 1'b1;
          m_valid <= 1'b1;
          m_bin   <= m_pend;
          m_err   <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("ready_o", int'(ready_o), int'(m_ready));
      chk("valid_o", int'(valid_o), int'(m_valid));
      chk("bin_o",   int'(bin_o),   m_bin);
      chk("err_o",   int'(err_o),   int'(m_err));
      if (valid_o) valid_cnt++;
    end
  end

  task automatic start_now(input logic [15:0] b);
    start_i = 1'b1;
    bcd_i   = b;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic do_req(input logic [15:0] b);
    @(negedge clk);
    start_now(b);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!valid_o && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!valid_o) chk("valid_timeout", 0, 1);
  endtask

  int cyc;
  int vc0;
  logic [15:0] rv;

  initial begin
    #3 rst = 1'b0;
    #1;
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_bin",   int'(bin_o),   0);
    chk("rst_err",   int'(err_o),   0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    do_req(16'h1234);
    chk("busy_1234", int'(ready_o), 0);
    wait_valid(cyc);
    chk("lat_1234", cyc, 14);
    chk("bin_1234", int'(bin_o), 1234);
    chk("err_1234", int'(err_o), 0);

    do_req(16'h9999);
    wait_valid(cyc);
    chk("bin_9999", int'(bin_o), 'h270F);
    chk("err_9999", int'(err_o), 0);
    do_req(16'h0000);
    wait_valid(cyc);
    chk("bin_0000", int'(bin_o), 0);

    do_req(16'h12A4);
    wait_valid(cyc);
    chk("lat_12A4", cyc, 0);
    chk("err_12A4", int'(err_o), 1);
    chk("bin_12A4", int'(bin_o), 0);
    chk("ready_12A4", int'(ready_o), 1);
    do_req(16'h0042);
    wait_valid(cyc);
    chk("bin_0042", int'(bin_o), 42);
    chk("err_0042", int'(err_o), 0);

    // Starts during a conversion are ignored; back-to-back start is accepted.
    @(negedge clk);
    #1 vc0 = valid_cnt;
    start_now(16'h0500);
    @(negedge clk);
    start_now(16'h0007);
    repeat (5) @(negedge clk);
    start_now(16'h0007);
    wait_valid(cyc);
    chk("bin_0500", int'(bin_o), 500);
    start_now(16'h0321);
    #1 chk("b2b_accept", int'(ready_o), 0);
    wait_valid(cyc);
    chk("bin_0321", int'(bin_o), 321);
    @(negedge clk);
    #1 chk("pulse_count", valid_cnt - vc0, 2);

    // Asynchronous reset in the middle of a conversion.
    do_req(16'h8765);
    repeat (6) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_ready", int'(ready_o), 1);
    chk("abort_valid", int'(valid_o), 0);
    chk("abort_bin",   int'(bin_o),   0);
    chk("abort_err",   int'(err_o),   0);
    @(negedge clk);
    rst = 1'b1;
    #1 vc0 = valid_cnt;
    repeat (20) @(negedge clk);
    #1 chk("abort_no_valid", valid_cnt - vc0, 0);
    do_req(16'h0001);
    wait_valid(cyc);
    chk("bin_0001", int'(bin_o), 1);

    // Random sweep over valid BCD values.
    for (int n = 0; n < 150; n++) begin
      for (int d = 0; d < 4; d++) rv[4*d +: 4] = 4'($urandom_range(9, 0));
      do_req(rv);
      wait_valid(cyc);
      chk("rand_bin", int'(bin_o), bcd_val(rv));
      chk("rand_err", int'(err_o), 0);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
